// File: rtl/renkon_conv_window.sv
`default_nettype none
// ============================================================================
// Module   : renkon_conv_window
// Brief    : 5x5 sliding-window generator (4 line buffers + 25 window regs)
//            feeding the convolution adder tree. Define
//            RENKON_WINDOW_STRIDE2_EN for stride-2 window output.
// Revision : 1.0 - initial release
// ============================================================================
module renkon_conv_window #(
  parameter int DWIDTH = 16,
  parameter int MAXW   = 32,
  parameter int SWIDTH = 6,
  parameter int FSIZE  = 5
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     _start,
  input  logic [SWIDTH-1:0]        _img_size,
  input  logic signed [DWIDTH-1:0] pixel,
  input  logic                     pixel_valid,
  output logic                     ready,
  output logic signed [DWIDTH-1:0] window [FSIZE*FSIZE],
  output logic                     out_valid,
  output logic                     frame_done
);

  localparam int                c_AW   = $clog2(MAXW);
  localparam int                c_NWIN = FSIZE * FSIZE;
  localparam logic [SWIDTH-1:0] c_MIN  = SWIDTH'(FSIZE);
  localparam logic [SWIDTH-1:0] c_MAX  = SWIDTH'(MAXW);
  localparam logic [SWIDTH-1:0] c_EDGE = SWIDTH'(FSIZE - 1);
  localparam logic [SWIDTH-1:0] c_ONE  = SWIDTH'(1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;
  logic [SWIDTH-1:0]        r_size;
  logic [SWIDTH-1:0]        r_row;
  logic [SWIDTH-1:0]        r_col;
  logic signed [DWIDTH-1:0] r_win [c_NWIN];
  logic signed [DWIDTH-1:0] r_lb  [FSIZE-1][MAXW];
  logic signed [DWIDTH-1:0] w_col_new [FSIZE];
  logic                     r_out_valid;
  logic                     r_frame_done;
  logic                     w_size_ok;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_in_window;
  logic                     w_stride_ok;
  logic [c_AW-1:0]          w_addr;

  assign w_size_ok   = (_img_size >= c_MIN) && (_img_size <= c_MAX);
  // A start pulse always takes priority over a pixel offered in the same cycle.
  assign w_accept    = pixel_valid && ready && !_start;
  assign w_last      = w_accept && (r_row == r_size - c_ONE) && (r_col == r_size - c_ONE);
  assign w_in_window = (r_row >= c_EDGE) && (r_col >= c_EDGE) && w_stride_ok;
  assign w_addr      = r_col[c_AW-1:0];

`ifdef RENKON_WINDOW_STRIDE2_EN
  // (row-4) and (col-4) even is the same as row and col even.
  assign w_stride_ok = ~r_row[0] & ~r_col[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (_start && w_size_ok) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (_start)      w_state_nxt = w_size_ok ? S_STREAM : S_IDLE;
        else if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == S_STREAM);
  end

  // Column entering the window: four buffered rows above, newest pixel below.
  always_comb begin
    for (int k = 0; k < FSIZE - 1; k++) begin
      w_col_new[k] = r_lb[k][w_addr];
    end
    w_col_new[FSIZE-1] = pixel;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < FSIZE - 2; k++) begin
        r_lb[k][w_addr] <= r_lb[k+1][w_addr];
      end
      r_lb[FSIZE-2][w_addr] <= pixel;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_size       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < c_NWIN; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_out_valid  <= w_accept && w_in_window;
      r_frame_done <= w_last;
      if (_start && (w_size_ok || ready)) begin
        r_row <= '0;
        r_col <= '0;
        if (w_size_ok) r_size <= _img_size;
      end else if (w_accept) begin
        if (r_col == r_size - c_ONE) begin
          r_col <= '0;
          r_row <= r_row + c_ONE;
        end else begin
          r_col <= r_col + c_ONE;
        end
        for (int r = 0; r < FSIZE; r++) begin
          for (int c = 0; c < FSIZE - 1; c++) begin
            r_win[r*FSIZE+c] <= r_win[r*FSIZE+c+1];
          end
          r_win[r*FSIZE+FSIZE-1] <= w_col_new[r];
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

  for (genvar i = 0; i < c_NWIN; i++) begin : g_win
    assign window[i] = r_win[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_renkon_conv_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_renkon_conv_window
// Brief    : Bench for renkon_conv_window; frame-level pixel model predicts
//            every window, valid strobe and frame_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_renkon_conv_window;

  localparam int DW   = 16;
  localparam int MAXW = 32;
  localparam int SW   = 6;

  logic                 clk = 1'b0;
  logic                 xrst;
  logic                 _start;
  logic [SW-1:0]        _img_size;
  logic signed [DW-1:0] pixel;
  logic                 pixel_valid;
  logic                 ready;
  logic signed [DW-1:0] window [25];
  logic                 out_valid;
  logic                 frame_done;

  always #5 clk = ~clk;

  renkon_conv_window #(.DWIDTH(DW), .MAXW(MAXW), .SWIDTH(SW), .FSIZE(5)) dut (
    .clk         (clk),
    .xrst        (xrst),
    ._start      (_start),
    ._img_size   (_img_size),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .ready       (ready),
    .window      (window),
    .out_valid   (out_valid),
    .frame_done  (frame_done)
  );

  int checks   = 0;
  int failures = 0;

  // Model: current frame's pixels in raster order plus position bookkeeping.
  bit                   m_stream;
  int                   m_n;
  int                   m_idx;
  logic signed [DW-1:0] img [0:1023];
  logic signed [DW-1:0] exp_win [25];
  int                   win_cnt;
  int                   done_cnt;
  int                   both_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count(input int n);
`ifdef RENKON_WINDOW_STRIDE2_EN
    return ((n - 3) / 2) * ((n - 3) / 2);
`else
    return (n - 4) * (n - 4);
`endif
  endfunction

  function automatic int exp_last_has_window(input int n);
`ifdef RENKON_WINDOW_STRIDE2_EN
    return ((n - 1) % 2 == 0) ? 1 : 0;
`else
    return (n > 0) ? 1 : 0;
`endif
  endfunction

  task automatic clear_counts();
    win_cnt  = 0;
    done_cnt = 0;
    both_cnt = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ready"}, 32'(ready), 0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 0);
    chk({pfx, "_frame_done"}, 32'(frame_done), 0);
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("%s_window[%0d]", pfx, i), window[i], 0);
    end
  endtask

  // One clock: drive, predict from the frame model, check the registered outputs.
  task automatic cycle(input bit st, input int sz, input bit pv, input logic signed [DW-1:0] px);
    bit acc;
    bit ev;
    bit ed;
    int r;
    int c;
    _start      = st;
    _img_size   = sz[SW-1:0];
    pixel_valid = pv;
    pixel       = px;
    chk("ready", 32'(ready), 32'(m_stream));
    acc = pv && m_stream && !st;
    ev  = 1'b0;
    ed  = 1'b0;
    @(posedge clk);
    #1;
    if (st) begin
      if (sz >= 5 && sz <= MAXW) begin
        m_stream = 1'b1;
        m_n      = sz;
        m_idx    = 0;
      end else begin
        m_stream = 1'b0;
      end
    end else if (acc) begin
      r = m_idx / m_n;
      c = m_idx % m_n;
      img[m_idx] = px;
      ev = (r >= 4) && (c >= 4);
`ifdef RENKON_WINDOW_STRIDE2_EN
      ev = ev && (r % 2 == 0) && (c % 2 == 0);
`endif
      if (ev) begin
        for (int i = 0; i < 25; i++) begin
          exp_win[i] = img[(r - 4 + i / 5) * m_n + (c - 4 + i % 5)];
        end
      end
      m_idx++;
      if (m_idx == m_n * m_n) begin
        ed       = 1'b1;
        m_stream = 1'b0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("frame_done", 32'(frame_done), 32'(ed));
    if (ev) begin
      for (int i = 0; i < 25; i++) begin
        chk($sformatf("window[%0d]", i), window[i], exp_win[i]);
      end
    end
    if (out_valid) win_cnt++;
    if (frame_done) done_cnt++;
    if (out_valid && frame_done) both_cnt++;
  endtask

  // mode 0: pattern y*16+x, continuous; 1: random data, 3-cycle stall after
  // every 2nd pixel; 2: random data, random pixel_valid.
  task automatic feed(input int mode, input int max_px);
    int sent;
    int budget;
    bit pv;
    logic signed [DW-1:0] px;
    sent   = 0;
    budget = 20000;
    while (m_stream && sent < max_px) begin
      if (budget == 0) begin
        checks++;
        failures++;
        $error("FAIL cycle_budget observed=%0d expected=%0d", sent, m_n * m_n);
        break;
      end
      budget--;
      if (mode == 0) px = DW'((m_idx / m_n) * 16 + (m_idx % m_n));
      else           px = DW'($urandom);
      pv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(1'b0, 0, pv, px);
      if (pv) sent++;
      if (mode == 1 && pv && (sent % 2 == 0)) begin
        repeat (3) cycle(1'b0, 0, 1'b0, DW'($urandom));
      end
    end
  endtask

  task automatic frame(input int n, input int mode, input string tag);
    clear_counts();
    cycle(1'b1, n, 1'b0, '0);
    feed(mode, 1 << 30);
    cycle(1'b0, 0, 1'b0, '0);
    chk({tag, "_win_count"}, win_cnt, exp_count(n));
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_with_last_window"}, both_cnt, exp_last_has_window(n));
  endtask

  initial begin
    xrst        = 1'b0;
    _start      = 1'b0;
    _img_size   = '0;
    pixel       = '0;
    pixel_valid = 1'b0;
    m_stream    = 1'b0;
    m_n         = 1;
    m_idx       = 0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    xrst = 1'b1;
    @(posedge clk);
    #1;

    frame(6, 0, "basic");
    frame(6, 1, "stall");
    frame(32, 2, "max");

    // Illegal sizes are ignored; pixels in IDLE do nothing.
    clear_counts();
    cycle(1'b1, 4, 1'b0, '0);
    cycle(1'b0, 0, 1'b1, 16'sd5);
    cycle(1'b1, 33, 1'b0, '0);
    repeat (3) cycle(1'b0, 0, 1'b1, DW'($urandom));
    chk("illegal_win_count", win_cnt, 0);
    frame(5, 2, "min");

    // Asynchronous reset in the middle of a frame.
    clear_counts();
    cycle(1'b1, 6, 1'b0, '0);
    feed(2, 20);
    xrst = 1'b0;
    #1;
    chk_all_zero("midreset");
    m_stream = 1'b0;
    @(posedge clk);
    #1;
    xrst = 1'b1;
    frame(6, 2, "after_reset");

    // Restart mid-frame with a pixel offered in the start cycle.
    cycle(1'b1, 7, 1'b0, '0);
    feed(2, 15);
    clear_counts();
    cycle(1'b1, 6, 1'b1, DW'($urandom));
    feed(2, 1 << 30);
    cycle(1'b0, 0, 1'b0, '0);
    chk("restart_win_count", win_cnt, exp_count(6));
    chk("restart_done_count", done_cnt, 1);

    // Restart with an illegal size abandons the frame silently.
    cycle(1'b1, 8, 1'b0, '0);
    feed(2, 40);
    clear_counts();
    cycle(1'b1, 2, 1'b0, '0);
    repeat (4) cycle(1'b0, 0, 1'b1, DW'($urandom));
    chk("abort_win_count", win_cnt, 0);
    chk("abort_done_count", done_cnt, 0);

    frame(8, 0, "n8");
    for (int k = 0; k < 3; k++) begin
      frame($urandom_range(5, 12), 2, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
